id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, with the operand-forwarding muxes in front of it.
//  Consumes the forward selects and stall from the hazard unit.
//  Feeds o_reg_d_EX / o_reg_wr_EX / o_mem_rd_EX back to the hazard unit.
//  Inserts a bubble on a load-use stall or a branch flush, and counts the bubbles inserted.
// PARAMETERS
//  DW     32  datapath width (operands, immediate, PC)
//  RW     5   register address width
//  CNT_W  16  width of the bubble counter
// PORTS
//  i_clk          in   1      clock; all state updates on rising edge
//  i_rst          in   1      synchronous reset, active-high
//  i_stall        in   1      load-use stall from hazard unit (o_stall)
//  i_flush        in   1      branch/jump taken; kill the instruction in ID
//  i_valid_ID     in   1      ID holds a real instruction
//  i_pc_ID        in   DW     PC of the ID instruction
//  i_rs_data      in   DW     register-file read port s
//  i_rt_data      in   DW     register-file read port t
//  i_imm          in   DW     sign/zero-extended immediate
//  i_reg_d        in   RW     destination register (already rd/rt-selected)
//  i_reg_wr       in   1      ID instruction writes the register file
//  i_mem_rd       in   1      ID instruction is a load
//  i_mem_wr       in   1      ID instruction is a store
//  i_alu_op       in   4      ALU operation code
//  i_alu_src      in   1      1 = ALU operand B is the immediate
//  i_forwardA     in   2      hazard-unit select for operand s
//  i_forwardB     in   2      hazard-unit select for operand t
//  i_fwd_EX       in   DW     ALU result currently in EX
//  i_fwd_MM       in   DW     MM-stage result (memory data for loads, else ALU result)
//  i_fwd_WB       in   DW     write-back data
//  o_valid_EX     out  1      EX holds a real instruction
//  o_pc_EX        out  DW     registered PC
//  o_op_a         out  DW     registered forwarded operand s
//  o_op_b         out  DW     registered forwarded operand t (ALU B / store data)
//  o_imm_EX       out  DW     registered immediate
//  o_reg_d_EX     out  RW     registered destination register
//  o_reg_wr_EX    out  1      registered register-write enable
//  o_mem_rd_EX    out  1      registered load flag
//  o_mem_wr_EX    out  1      registered store flag
//  o_alu_op_EX    out  4      registered ALU op
//  o_alu_src_EX   out  1      registered ALU source select
//  o_bubble_cnt   out  CNT_W  bubbles inserted since reset; saturating
// BEHAVIOUR
//  Forward mux (combinational, ID side), same encoding for A (from i_rs_data) and B (from i_rt_data):
//   00 -> register-file data; 01 -> i_fwd_EX; 10 -> i_fwd_MM; 11 -> i_fwd_WB.
//  Latency: exactly 1 cycle from ID inputs to EX outputs. No hold state; ID/EX never freezes.
//  Per-edge priority: i_rst > i_flush > i_stall > load.
//  Reset:
//   - All outputs go to 0, including o_valid_EX, every control bit, every data field and o_bubble_cnt.
//  Bubble (i_flush=1, or i_stall=1, or i_valid_ID=0):
//   - o_valid_EX, o_reg_wr_EX, o_mem_rd_EX and o_mem_wr_EX go to 0.
//   - o_reg_d_EX, o_alu_op_EX and o_alu_src_EX go to 0.
//   - All data outputs go to 0.
//  Load (i_valid_ID=1, no stall, no flush):
//   - Every field is captured; o_op_a and o_op_b are captured after the forward mux.
//  Bubble counter:
//   - +1 on each edge where (i_stall | i_flush) and !i_rst.
//   - i_valid_ID=0 alone does not count.
//   - Saturates at 2^CNT_W-1; no wrap.
//  Stall and flush in the same cycle: one bubble, counted once.
//  Reset asserted mid-stall: the reset values win, and the counter clears on that edge.
//  Load-use sequence:
//   - Cycle n: a load is in EX and the dependent instruction is in ID, so i_stall=1 and a bubble enters EX.
//   - Cycle n+1: the hazard unit reports select 10, so the operand is taken from i_fwd_MM (load data).
//  Register $0 needs no gating here; the hazard unit never selects forwarding for $0.
// TESTING
//  1. Reset:
//     i_rst=1 for 2 cycles with random inputs -> all outputs 0.
//     Release -> the first valid ID instruction appears on the next edge.
//  2. Forward select:
//     i_rs_data=1, i_fwd_EX=2, i_fwd_MM=3, i_fwd_WB=4.
//     i_forwardA=00/01/10/11 on successive cycles -> o_op_a = 1,2,3,4 one cycle later.
//     Repeat with B.
//  3. Load-use:
//     i_stall=1 for one cycle with i_reg_wr=1, i_mem_wr=1 -> o_valid_EX=0, o_reg_wr_EX=0, o_mem_wr_EX=0, o_bubble_cnt=1.
//     Next cycle i_forwardA=10, i_fwd_MM=0xCAFE -> o_op_a=0xCAFE.
//  4. Flush and stall together:
//     i_flush=i_stall=1 -> a single bubble, o_bubble_cnt increments by exactly 1.
//  5. Saturation:
//     CNT_W=4, hold i_stall=1 for 20 cycles -> o_bubble_cnt stops at 15.
//     Then i_rst=1 for 1 cycle -> 0.
//  6. Invalid ID:
//     i_valid_ID=0 with i_mem_rd=1 -> o_mem_rd_EX=0, o_valid_EX=0, counter unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding muxes and bubble counter
module id_ex_stage #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_valid_ID,
    input  logic [DW-1:0]    i_pc_ID,
    input  logic [DW-1:0]    i_rs_data,
    input  logic [DW-1:0]    i_rt_data,
    input  logic [DW-1:0]    i_imm,
    input  logic [RW-1:0]    i_reg_d,
    input  logic             i_reg_wr,
    input  logic             i_mem_rd,
    input  logic             i_mem_wr,
    input  logic [3:0]       i_alu_op,
    input  logic             i_alu_src,
    input  logic [1:0]       i_forwardA,
    input  logic [1:0]       i_forwardB,
    input  logic [DW-1:0]    i_fwd_EX,
    input  logic [DW-1:0]    i_fwd_MM,
    input  logic [DW-1:0]    i_fwd_WB,
    output logic             o_valid_EX,
    output logic [DW-1:0]    o_pc_EX,
    output logic [DW-1:0]    o_op_a,
    output logic [DW-1:0]    o_op_b,
    output logic [DW-1:0]    o_imm_EX,
    output logic [RW-1:0]    o_reg_d_EX,
    output logic             o_reg_wr_EX,
    output logic             o_mem_rd_EX,
    output logic             o_mem_wr_EX,
    output logic [3:0]       o_alu_op_EX,
    output logic             o_alu_src_EX,
    output logic [CNT_W-1:0] o_bubble_cnt
);
    logic             valid_q, valid_d;
    logic [DW-1:0]    pc_q, pc_d, op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
    logic [RW-1:0]    reg_d_q, reg_d_d;
    logic             reg_wr_q, reg_wr_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             alu_src_q, alu_src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    fwd_a, fwd_b;
    logic             bubble;

    // Forward muxes, bubble decision and next-state values; a bubble zeroes every field
    always_comb begin
        fwd_a     = i_forwardA[1] ? (i_forwardA[0] ? i_fwd_WB : i_fwd_MM)
                                  : (i_forwardA[0] ? i_fwd_EX : i_rs_data);
        fwd_b     = i_forwardB[1] ? (i_forwardB[0] ? i_fwd_WB : i_fwd_MM)
                                  : (i_forwardB[0] ? i_fwd_EX : i_rt_data);
        bubble    = i_flush | i_stall | ~i_valid_ID;
        valid_d   = ~bubble;
        pc_d      = bubble ? '0 : i_pc_ID;
        op_a_d    = bubble ? '0 : fwd_a;
        op_b_d    = bubble ? '0 : fwd_b;
        imm_d     = bubble ? '0 : i_imm;
        reg_d_d   = bubble ? '0 : i_reg_d;
        reg_wr_d  = ~bubble & i_reg_wr;
        mem_rd_d  = ~bubble & i_mem_rd;
        mem_wr_d  = ~bubble & i_mem_wr;
        alu_op_d  = bubble ? '0 : i_alu_op;
        alu_src_d = ~bubble & i_alu_src;
        cnt_d     = ((i_stall | i_flush) && cnt_q != {CNT_W{1'b1}})
                    ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    // Pipeline register; reset clears everything including the bubble counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            imm_q     <= '0;
            reg_d_q   <= '0;
            reg_wr_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            alu_op_q  <= '0;
            alu_src_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            imm_q     <= imm_d;
            reg_d_q   <= reg_d_d;
            reg_wr_q  <= reg_wr_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_valid_EX   = valid_q;
    assign o_pc_EX      = pc_q;
    assign o_op_a       = op_a_q;
    assign o_op_b       = op_b_q;
    assign o_imm_EX     = imm_q;
    assign o_reg_d_EX   = reg_d_q;
    assign o_reg_wr_EX  = reg_wr_q;
    assign o_mem_rd_EX  = mem_rd_q;
    assign o_mem_wr_EX  = mem_wr_q;
    assign o_alu_op_EX  = alu_op_q;
    assign o_alu_src_EX = alu_src_q;
    assign o_bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with a 4-bit counter twin for saturation
module tb_id_ex_stage;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [3:0]  op;
        logic        src;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } out_t;

    logic        i_clk = 0, i_rst = 0, i_stall = 0, i_flush = 0, i_valid_ID = 0;
    logic [31:0] i_pc_ID = 0, i_rs_data = 0, i_rt_data = 0, i_imm = 0;
    logic [4:0]  i_reg_d = 0;
    logic        i_reg_wr = 0, i_mem_rd = 0, i_mem_wr = 0, i_alu_src = 0;
    logic [3:0]  i_alu_op = 0;
    logic [1:0]  i_forwardA = 0, i_forwardB = 0;
    logic [31:0] i_fwd_EX = 0, i_fwd_MM = 0, i_fwd_WB = 0;
    logic        o_valid_EX, o_reg_wr_EX, o_mem_rd_EX, o_mem_wr_EX, o_alu_src_EX;
    logic [31:0] o_pc_EX, o_op_a, o_op_b, o_imm_EX;
    logic [4:0]  o_reg_d_EX;
    logic [3:0]  o_alu_op_EX;
    logic [15:0] o_bubble_cnt;
    logic        s_valid_EX, s_reg_wr_EX, s_mem_rd_EX, s_mem_wr_EX, s_alu_src_EX;
    logic [31:0] s_pc_EX, s_op_a, s_op_b, s_imm_EX;
    logic [4:0]  s_reg_d_EX;
    logic [3:0]  s_alu_op_EX;
    logic [3:0]  s_bubble_cnt;

    out_t  exp_q[$];
    string name_q[$];
    int    n_chk = 0, n_fail = 0, n_vec = 0;
    logic  g_reg_wr = 1, g_mem_rd = 0, g_mem_wr = 0;

    always #5 i_clk = ~i_clk;

    id_ex_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid_ID(i_valid_ID),
        .i_pc_ID(i_pc_ID), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_reg_d(i_reg_d), .i_reg_wr(i_reg_wr), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
        .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
        .i_fwd_EX(i_fwd_EX), .i_fwd_MM(i_fwd_MM), .i_fwd_WB(i_fwd_WB),
        .o_valid_EX(o_valid_EX), .o_pc_EX(o_pc_EX), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .o_imm_EX(o_imm_EX), .o_reg_d_EX(o_reg_d_EX), .o_reg_wr_EX(o_reg_wr_EX),
        .o_mem_rd_EX(o_mem_rd_EX), .o_mem_wr_EX(o_mem_wr_EX), .o_alu_op_EX(o_alu_op_EX),
        .o_alu_src_EX(o_alu_src_EX), .o_bubble_cnt(o_bubble_cnt)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid_ID(i_valid_ID),
        .i_pc_ID(i_pc_ID), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_reg_d(i_reg_d), .i_reg_wr(i_reg_wr), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
        .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
        .i_fwd_EX(i_fwd_EX), .i_fwd_MM(i_fwd_MM), .i_fwd_WB(i_fwd_WB),
        .o_valid_EX(s_valid_EX), .o_pc_EX(s_pc_EX), .o_op_a(s_op_a), .o_op_b(s_op_b),
        .o_imm_EX(s_imm_EX), .o_reg_d_EX(s_reg_d_EX), .o_reg_wr_EX(s_reg_wr_EX),
        .o_mem_rd_EX(s_mem_rd_EX), .o_mem_wr_EX(s_mem_wr_EX), .o_alu_op_EX(s_alu_op_EX),
        .o_alu_src_EX(s_alu_src_EX), .o_bubble_cnt(s_bubble_cnt)
    );

    // Apply one ID-side vector on the falling edge and queue what EX must show after the next rising edge
    task automatic drive(input logic rst, stall, flush, valid, input logic [1:0] fa, fb,
                         input logic [31:0] rs, rt, ea, eb, input logic [15:0] ec, input string nm);
        out_t e;
        logic bub;
        @(negedge i_clk);
        n_vec++;
        i_rst = rst; i_stall = stall; i_flush = flush; i_valid_ID = valid;
        i_forwardA = fa; i_forwardB = fb; i_rs_data = rs; i_rt_data = rt;
        i_pc_ID = 32'h100 + 32'(n_vec * 4); i_imm = 32'(n_vec * 3) ^ 32'hA500_0000;
        i_reg_d = 5'(n_vec); i_alu_op = 4'(n_vec); i_alu_src = n_vec[0];
        i_reg_wr = g_reg_wr; i_mem_rd = g_mem_rd; i_mem_wr = g_mem_wr;
        bub = rst | stall | flush | ~valid;
        e.valid = ~bub;
        e.pc    = bub ? 32'd0 : i_pc_ID;
        e.a     = ea;
        e.b     = eb;
        e.imm   = bub ? 32'd0 : i_imm;
        e.rd    = bub ? 5'd0 : i_reg_d;
        e.rw    = ~bub & g_reg_wr;
        e.mr    = ~bub & g_mem_rd;
        e.mw    = ~bub & g_mem_wr;
        e.op    = bub ? 4'd0 : i_alu_op;
        e.src   = ~bub & i_alu_src;
        e.cnt   = ec;
        e.cnt4  = ec > 16'd15 ? 4'd15 : ec[3:0];
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one EX snapshot per cycle, compared against the oldest queued expectation
    initial forever begin
        out_t act, e;
        string nm;
        @(posedge i_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            act = '{o_valid_EX, o_pc_EX, o_op_a, o_op_b, o_imm_EX, o_reg_d_EX, o_reg_wr_EX,
                    o_mem_rd_EX, o_mem_wr_EX, o_alu_op_EX, o_alu_src_EX, o_bubble_cnt, s_bubble_cnt};
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h required %h (op_a %h/%h op_b %h/%h cnt %0d/%0d cnt4 %0d/%0d)",
                         nm, act, e, act.a, e.a, act.b, e.b, act.cnt, e.cnt, act.cnt4, e.cnt4);
            end
        end
    end

    initial begin
        i_fwd_EX = 2; i_fwd_MM = 3; i_fwd_WB = 4;
        repeat (2) drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
                         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                         $urandom, $urandom, 0, 0, 0, "reset");
        drive(0, 0, 0, 1, 2'b00, 2'b00, 1, 11, 1, 11, 0, "fwdA00");
        drive(0, 0, 0, 1, 2'b01, 2'b00, 1, 11, 2, 11, 0, "fwdA01");
        drive(0, 0, 0, 1, 2'b10, 2'b00, 1, 11, 3, 11, 0, "fwdA10");
        drive(0, 0, 0, 1, 2'b11, 2'b00, 1, 11, 4, 11, 0, "fwdA11");
        drive(0, 0, 0, 1, 2'b00, 2'b00, 9, 1, 9, 1, 0, "fwdB00");
        drive(0, 0, 0, 1, 2'b00, 2'b01, 9, 1, 9, 2, 0, "fwdB01");
        drive(0, 0, 0, 1, 2'b00, 2'b10, 9, 1, 9, 3, 0, "fwdB10");
        drive(0, 0, 0, 1, 2'b00, 2'b11, 9, 1, 9, 4, 0, "fwdB11");
        g_mem_wr = 1;
        drive(0, 1, 0, 1, 2'b00, 2'b00, 5, 6, 0, 0, 1, "loaduse_stall");
        g_mem_wr = 0;
        i_fwd_MM = 32'hCAFE;
        drive(0, 0, 0, 1, 2'b10, 2'b00, 5, 6, 32'hCAFE, 6, 1, "loaduse_fwd");
        drive(0, 1, 1, 1, 2'b01, 2'b01, 5, 6, 0, 0, 2, "flush_stall");
        drive(0, 0, 1, 1, 2'b01, 2'b01, 5, 6, 0, 0, 3, "flush_only");
        drive(0, 0, 0, 1, 2'b11, 2'b10, 5, 6, 4, 32'hCAFE, 3, "load_after_flush");
        g_mem_rd = 1;
        drive(0, 0, 0, 0, 2'b00, 2'b00, 7, 8, 0, 0, 3, "invalid_id");
        drive(0, 0, 0, 1, 2'b00, 2'b00, 7, 8, 7, 8, 3, "load_mem_rd");
        g_mem_rd = 0;
        for (int k = 1; k <= 20; k++)
            drive(0, 1, 0, 1, 2'b00, 2'b00, 7, 8, 0, 0, 16'(3 + k), "sat_stall");
        drive(1, 1, 0, 1, 2'b00, 2'b00, 7, 8, 0, 0, 0, "reset_mid_stall");
        drive(0, 0, 0, 1, 2'b01, 2'b11, 7, 8, 2, 4, 0, "after_reset");
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge i_clk);
        #2;
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
